// File: rtl/cam_reg_init_seq_if.sv
// ---------------------------------------------------------------------------
// cam_reg_init_seq_if
// Command/response bundle between the camera register-init sequencer and an
// SCCB write master. One write command is in flight at a time: the
// sequencer raises cmd_valid with cmd_addr/cmd_data until cmd_ready is seen.
// The SCCB master then ends that write with a one-cycle resp_valid pulse,
// with resp_nack showing whether the slave refused the write.
//
// Signals
//   cmd_valid   write request (sequencer -> SCCB master)
//   cmd_ready   command accepted (SCCB master -> sequencer)
//   cmd_addr    16-bit register address, stable while cmd_valid=1
//   cmd_data    8-bit register data, stable while cmd_valid=1
//   resp_valid  one-cycle end-of-write pulse
//   resp_nack   qualified by resp_valid, 1 = slave NACK
//
// Modports
//   master  the sequencer side (drives the command)
//   slave   the SCCB master side (drives ready and the response)
// ---------------------------------------------------------------------------
interface cam_reg_init_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        resp_valid;
  logic        resp_nack;

  modport master (
    output cmd_valid,
    output cmd_addr,
    output cmd_data,
    input  cmd_ready,
    input  resp_valid,
    input  resp_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_addr,
    input  cmd_data,
    output cmd_ready,
    output resp_valid,
    output resp_nack
  );
endinterface

// File: rtl/cam_reg_init_seq.sv
// ---------------------------------------------------------------------------
// cam_reg_init_seq
// Walks a camera register table held in a synchronous ROM. Each entry is
// written to the sensor through an SCCB master, one command at a time.
// An entry whose address is 16'hFFFF is not written. Instead, its data
// byte is a pause length in delay units.
//
// Optional feature (compile-time macro CAM_INIT_RETRY_EN):
//   defined   - a NACKed write is re-sent up to MAX_RETRY times before the
//               sequence aborts; the MAX_RETRY parameter and the retry
//               counter exist only in this build
//   undefined - any NACK aborts the sequence at once
//
// Parameters
//   TBL_LEN    number of table entries (indices 0..TBL_LEN-1)
//   DLY_UNIT   clk_50M cycles per delay unit
//   MAX_RETRY  re-sends per entry on NACK (CAM_INIT_RETRY_EN builds only)
//
// Ports
//   clk_50M     sole clock, rising edge
//   reset       asynchronous active-high reset
//   initial_en  level from the power-on sequencer; low aborts and rewinds
//   tbl_index   ROM read address
//   tbl_data    ROM data {reg_addr[15:0], reg_data[7:0]}, one cycle latency
//   cmd_bus     command/response bundle (master side)
//   init_done   whole table written successfully (held)
//   init_err    aborted on an unrecovered NACK (held)
//   err_index   index of the failing entry while init_err=1
// ---------------------------------------------------------------------------
module cam_reg_init_seq #(
  parameter logic [7:0]  TBL_LEN   = 8'd200,
  parameter logic [15:0] DLY_UNIT  = 16'd50000
`ifdef CAM_INIT_RETRY_EN
  ,
  parameter logic [1:0]  MAX_RETRY = 2'd3
`endif
) (
  input  logic                       clk_50M,
  input  logic                       reset,
  input  logic                       initial_en,
  output logic [7:0]                 tbl_index,
  input  logic [23:0]                tbl_data,
  cam_reg_init_seq_if.master         cmd_bus,
  output logic                       init_done,
  output logic                       init_err,
  output logic [7:0]                 err_index
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_LATCH     = 4'd2,
    ST_SEND      = 4'd3,
    ST_WAIT_RESP = 4'd4,
    ST_DELAY     = 4'd5,
    ST_NEXT      = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } state_t;

  localparam logic [15:0] DELAY_ADDR = 16'hFFFF;
  localparam logic [7:0]  LAST_INDEX = TBL_LEN - 8'd1;

  state_t      state_r,     state_s;
  logic [7:0]  index_r,     index_s;
  logic        cmd_valid_r, cmd_valid_s;
  logic [15:0] cmd_addr_r,  cmd_addr_s;
  logic [7:0]  cmd_data_r,  cmd_data_s;
  logic        done_r,      done_s;
  logic        err_r,       err_s;
  logic [7:0]  err_index_r, err_index_s;
  logic [23:0] dly_cnt_r,   dly_cnt_s;
  logic [23:0] dly_load_s;
`ifdef CAM_INIT_RETRY_EN
  logic [1:0]  retry_r,     retry_s;
`endif

  // Pause length of a delay entry; the 24-bit product cannot overflow for
  // an 8-bit count times the default 16-bit unit.
  assign dly_load_s = 24'(tbl_data[7:0]) * 24'(DLY_UNIT);

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    cmd_valid_s = cmd_valid_r;
    cmd_addr_s  = cmd_addr_r;
    cmd_data_s  = cmd_data_r;
    done_s      = done_r;
    err_s       = err_r;
    err_index_s = err_index_r;
    dly_cnt_s   = dly_cnt_r;
`ifdef CAM_INIT_RETRY_EN
    retry_s     = retry_r;
`endif

    if (!initial_en) begin
      // Losing initial_en aborts from any state, even mid-handshake, and
      // rewinds to entry 0. err_index keeps its last failing entry.
      state_s     = ST_IDLE;
      index_s     = 8'd0;
      cmd_valid_s = 1'b0;
      done_s      = 1'b0;
      err_s       = 1'b0;
      dly_cnt_s   = 24'd0;
`ifdef CAM_INIT_RETRY_EN
      retry_s     = 2'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_FETCH;
          index_s = 8'd0;
        end

        // The ROM needs this cycle to present the entry for index_r.
        ST_FETCH: begin
          state_s = ST_LATCH;
        end

        ST_LATCH: begin
          cmd_addr_s = tbl_data[23:8];
          cmd_data_s = tbl_data[7:0];
`ifdef CAM_INIT_RETRY_EN
          retry_s    = 2'd0;
`endif
          if (tbl_data[23:8] == DELAY_ADDR) begin
            state_s   = ST_DELAY;
            dly_cnt_s = dly_load_s;
          end else begin
            state_s     = ST_SEND;
            cmd_valid_s = 1'b1;
          end
        end

        ST_SEND: begin
          if (cmd_valid_r && cmd_ready_s()) begin
            cmd_valid_s = 1'b0;
            state_s     = ST_WAIT_RESP;
          end else begin
            cmd_valid_s = 1'b1;
          end
        end

        // resp_nack has no meaning until resp_valid qualifies it.
        ST_WAIT_RESP: begin
          if (cmd_bus.resp_valid) begin
            if (!cmd_bus.resp_nack) begin
              state_s = ST_NEXT;
            end else begin
`ifdef CAM_INIT_RETRY_EN
              if (retry_r < MAX_RETRY) begin
                retry_s     = retry_r + 2'd1;
                state_s     = ST_SEND;
                cmd_valid_s = 1'b1;
              end else begin
                state_s     = ST_ERROR;
                err_s       = 1'b1;
                err_index_s = index_r;
              end
`else
              state_s     = ST_ERROR;
              err_s       = 1'b1;
              err_index_s = index_r;
`endif
            end
          end else begin
            state_s = ST_WAIT_RESP;
          end
        end

        // A count of N keeps the sequencer here for N cycles; a zero-length
        // pause leaves after a single cycle.
        ST_DELAY: begin
          if (dly_cnt_r <= 24'd1) begin
            dly_cnt_s = 24'd0;
            state_s   = ST_NEXT;
          end else begin
            dly_cnt_s = dly_cnt_r - 24'd1;
          end
        end

        ST_NEXT: begin
          if (index_r == LAST_INDEX) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            index_s = index_r + 8'd1;
            state_s = ST_FETCH;
          end
        end

        // Terminal until initial_en drops.
        ST_DONE: begin
          done_s = 1'b1;
        end

        ST_ERROR: begin
          err_s = 1'b1;
        end

        default: begin
          state_s     = ST_IDLE;
          index_s     = 8'd0;
          cmd_valid_s = 1'b0;
          done_s      = 1'b0;
          err_s       = 1'b0;
        end
      endcase
    end
  end

  // Accept test kept in one place so the SEND branch reads as a handshake.
  function automatic logic cmd_ready_s();
    return cmd_bus.cmd_ready;
  endfunction

  // State and output registers.
  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      index_r     <= 8'd0;
      cmd_valid_r <= 1'b0;
      cmd_addr_r  <= 16'd0;
      cmd_data_r  <= 8'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      err_index_r <= 8'd0;
      dly_cnt_r   <= 24'd0;
`ifdef CAM_INIT_RETRY_EN
      retry_r     <= 2'd0;
`endif
    end else begin
      state_r     <= state_s;
      index_r     <= index_s;
      cmd_valid_r <= cmd_valid_s;
      cmd_addr_r  <= cmd_addr_s;
      cmd_data_r  <= cmd_data_s;
      done_r      <= done_s;
      err_r       <= err_s;
      err_index_r <= err_index_s;
      dly_cnt_r   <= dly_cnt_s;
`ifdef CAM_INIT_RETRY_EN
      retry_r     <= retry_s;
`endif
    end
  end

  assign tbl_index         = index_r;
  assign cmd_bus.cmd_valid = cmd_valid_r;
  assign cmd_bus.cmd_addr  = cmd_addr_r;
  assign cmd_bus.cmd_data  = cmd_data_r;
  assign init_done         = done_r;
  assign init_err          = err_r;
  assign err_index         = err_index_r;

endmodule

// File: tb/tb_cam_reg_init_seq.sv
// ---------------------------------------------------------------------------
// tb_cam_reg_init_seq
// Directed bench for cam_reg_init_seq with a 3-entry table and a 10-cycle
// delay unit. The bench plays both the synchronous ROM and the SCCB master.
// Inputs change, and outputs are sampled, on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cam_reg_init_seq;
  logic        clk_50M;
  logic        reset;
  logic        initial_en;
  logic [7:0]  tbl_index;
  logic [23:0] tbl_data;
  logic        init_done;
  logic        init_err;
  logic [7:0]  err_index;
  logic [23:0] rom [0:3];

  int checks;
  int errors;

`ifdef CAM_INIT_RETRY_EN
  localparam int EXP_SENDS = 4;
`else
  localparam int EXP_SENDS = 1;
`endif

  cam_reg_init_seq_if bus ();

  cam_reg_init_seq #(
    .TBL_LEN  (8'd3),
    .DLY_UNIT (16'd10)
  ) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .initial_en (initial_en),
    .tbl_index  (tbl_index),
    .tbl_data   (tbl_data),
    .cmd_bus    (bus),
    .init_done  (init_done),
    .init_err   (init_err),
    .err_index  (err_index)
  );

  initial begin
    clk_50M = 1'b0;
    forever #10 clk_50M = ~clk_50M;
  end

  // Synchronous ROM: data follows the address one edge later.
  always @(posedge clk_50M) tbl_data <= rom[tbl_index[1:0]];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  // Act as the SCCB master for one command: hold ready low rdy_wait cycles,
  // accept, then answer after ack_lat cycles (with resp_nack noise meanwhile).
  task automatic serve(input int rdy_wait, input int ack_lat, input logic nack,
                       output logic [15:0] a, output logic [7:0] d);
    int   n;
    logic stable;
    logic quiet;
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 100) begin
      @(negedge clk_50M);
      n++;
    end
    check("cmd_valid_seen", 32'(bus.cmd_valid), 32'd1);
    a = bus.cmd_addr;
    d = bus.cmd_data;
    stable = 1'b1;
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk_50M);
      if (bus.cmd_valid !== 1'b1 || bus.cmd_addr !== a || bus.cmd_data !== d) stable = 1'b0;
    end
    check("cmd_hold_stable", 32'(stable), 32'd1);
    bus.cmd_ready = 1'b1;
    @(negedge clk_50M);
    bus.cmd_ready = 1'b0;
    check("cmd_valid_drop", 32'(bus.cmd_valid), 32'd0);
    quiet = 1'b1;
    bus.resp_nack = 1'b1;
    for (int i = 0; i < ack_lat; i++) begin
      @(negedge clk_50M);
      if (bus.cmd_valid !== 1'b0) quiet = 1'b0;
    end
    check("single_outstanding", 32'(quiet), 32'd1);
    bus.resp_valid = 1'b1;
    bus.resp_nack  = nack;
    @(negedge clk_50M);
    bus.resp_valid = 1'b0;
    bus.resp_nack  = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    logic        quiet;
    int          n;
    int          sends;

    checks = 0;
    errors = 0;
    reset = 1'b1;
    initial_en = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_nack = 1'b0;
    rom[0] = 24'h300882;
    rom[1] = 24'h310303;
    rom[2] = 24'h3017FF;
    rom[3] = 24'h000000;

    // Reset state
    cycles(2);
    check("rst_tbl_index", 32'(tbl_index), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
    check("rst_cmd_data", 32'(bus.cmd_data), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_err", 32'(init_err), 32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Full table, always ready, ACK after 10 cycles
    initial_en = 1'b1;
    cycles(2);
    check("first_valid_edge2", 32'(bus.cmd_valid), 32'd0);
    cycles(1);
    check("first_valid_edge3", 32'(bus.cmd_valid), 32'd1);
    serve(0, 10, 1'b0, a, d);
    check("t1_addr0", 32'(a), 32'h3008);
    check("t1_data0", 32'(d), 32'h82);
    serve(0, 10, 1'b0, a, d);
    check("t1_addr1", 32'(a), 32'h3103);
    check("t1_data1", 32'(d), 32'h03);
    serve(0, 10, 1'b0, a, d);
    check("t1_addr2", 32'(a), 32'h3017);
    check("t1_data2", 32'(d), 32'hFF);
    cycles(1);
    check("t1_init_done", 32'(init_done), 32'd1);
    check("t1_init_err", 32'(init_err), 32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50M);
      if (bus.cmd_valid !== 1'b0) quiet = 1'b0;
    end
    check("t1_done_no_restart", 32'(quiet), 32'd1);
    check("t1_done_held", 32'(init_done), 32'd1);
    initial_en = 1'b0;
    cycles(1);
    check("t1_drop_done", 32'(init_done), 32'd0);
    check("t1_drop_index", 32'(tbl_index), 32'd0);

    // Back-pressure: ready held low 20 cycles on entry 0
    cycles(1);
    initial_en = 1'b1;
    serve(20, 10, 1'b0, a, d);
    check("t2_addr0", 32'(a), 32'h3008);
    check("t2_data0", 32'(d), 32'h82);
    serve(0, 5, 1'b0, a, d);
    serve(0, 5, 1'b0, a, d);
    cycles(1);
    check("t2_init_done", 32'(init_done), 32'd1);

    // Delay entry 0xFFFF/0x02 with 10-cycle unit: 20 cycles in DELAY,
    // entry 2 goes valid 26 edges after the entry-0 response edge
    initial_en = 1'b0;
    cycles(2);
    rom[1] = 24'hFFFF02;
    initial_en = 1'b1;
    serve(0, 3, 1'b0, a, d);
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 100) begin
      @(negedge clk_50M);
      n++;
    end
    check("t3_delay_gap", 32'(n), 32'd26);
    check("t3_index_after", 32'(tbl_index), 32'd2);
    check("t3_addr2", 32'(bus.cmd_addr), 32'h3017);
    serve(0, 3, 1'b0, a, d);
    cycles(1);
    check("t3_init_done", 32'(init_done), 32'd1);

    // Persistent NACK on entry 1
    initial_en = 1'b0;
    cycles(2);
    rom[1] = 24'h310303;
    initial_en = 1'b1;
    serve(0, 4, 1'b0, a, d);
    sends = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (bus.cmd_valid !== 1'b1 && init_err !== 1'b1 && n < 50) begin
        @(negedge clk_50M);
        n++;
      end
      if (bus.cmd_valid === 1'b1) begin
        serve(0, 4, 1'b1, a, d);
        sends++;
      end
    end
    check("t4_sends", 32'(sends), 32'(EXP_SENDS));
    check("t4_nack_addr", 32'(a), 32'h3103);
    check("t4_init_err", 32'(init_err), 32'd1);
    check("t4_err_index", 32'(err_index), 32'd1);
    check("t4_init_done", 32'(init_done), 32'd0);
    check("t4_err_quiet", 32'(bus.cmd_valid), 32'd0);
    initial_en = 1'b0;
    cycles(1);
    check("t4_drop_err", 32'(init_err), 32'd0);

    // initial_en dropped during WAIT_RESP of entry 1, then a late response
    cycles(1);
    initial_en = 1'b1;
    serve(0, 4, 1'b0, a, d);
    n = 0;
    while (bus.cmd_valid !== 1'b1 && n < 50) begin
      @(negedge clk_50M);
      n++;
    end
    check("t5_entry1_valid", 32'(bus.cmd_valid), 32'd1);
    bus.cmd_ready = 1'b1;
    @(negedge clk_50M);
    bus.cmd_ready = 1'b0;
    initial_en = 1'b0;
    @(negedge clk_50M);
    check("t5_abort_index", 32'(tbl_index), 32'd0);
    check("t5_abort_valid", 32'(bus.cmd_valid), 32'd0);
    bus.resp_valid = 1'b1;
    @(negedge clk_50M);
    bus.resp_valid = 1'b0;
    cycles(4);
    check("t5_late_resp_index", 32'(tbl_index), 32'd0);
    check("t5_late_resp_done", 32'(init_done), 32'd0);
    initial_en = 1'b1;
    cycles(3);
    check("t5_restart_valid", 32'(bus.cmd_valid), 32'd1);
    check("t5_restart_addr", 32'(bus.cmd_addr), 32'h3008);
    serve(0, 4, 1'b0, a, d);
    serve(0, 4, 1'b0, a, d);
    serve(0, 4, 1'b0, a, d);
    cycles(1);
    check("t5_init_done", 32'(init_done), 32'd1);

    // Asynchronous reset in the middle of a delay entry
    initial_en = 1'b0;
    cycles(2);
    rom[1] = 24'hFFFF02;
    initial_en = 1'b1;
    serve(0, 4, 1'b0, a, d);
    cycles(5);
    check("t6_in_delay_index", 32'(tbl_index), 32'd1);
    #5;
    reset = 1'b1;
    #1;
    check("t6_rst_tbl_index", 32'(tbl_index), 32'd0);
    check("t6_rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("t6_rst_cmd_addr", 32'(bus.cmd_addr), 32'd0);
    check("t6_rst_cmd_data", 32'(bus.cmd_data), 32'd0);
    check("t6_rst_init_done", 32'(init_done), 32'd0);
    check("t6_rst_init_err", 32'(init_err), 32'd0);
    check("t6_rst_err_index", 32'(err_index), 32'd0);
    initial_en = 1'b0;
    cycles(2);
    reset = 1'b0;
    cycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
